// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch controller state encoding and constants
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: single-entry instruction/PC buffer feeding IF/ID
module fetch_buf import fetch_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             flush,
    input  logic             cons,
    input  logic [WIDTH-1:0] load_instr,
    input  logic [WIDTH-1:0] load_pc,
    output logic             valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            instr <= WIDTH'(NOP_INSTR);
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (cons) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: one-outstanding instruction fetch sequencer with redirect drain
module fetch_ctrl import fetch_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pcf_i,
    input  logic             redirect_i,
    input  logic             stall_d_i,
    output logic             pc_en_o,
    output logic             imem_req_valid_o,
    output logic [WIDTH-1:0] imem_req_addr_o,
    input  logic             imem_req_ready_i,
    input  logic             imem_rsp_valid_i,
    input  logic [WIDTH-1:0] imem_rsp_data_i,
    output logic             instr_valid_o,
    output logic [WIDTH-1:0] instr_o,
    output logic [WIDTH-1:0] instr_pc_o
);
    fetch_state_t state, state_n;
    logic [WIDTH-1:0] req_pc;
    logic cons, free, hs, accept;
    assign cons            = instr_valid_o & ~stall_d_i;
    assign free            = ~instr_valid_o | cons;
    assign hs              = imem_req_valid_o & imem_req_ready_i;
    assign accept          = (state == WAIT) & imem_rsp_valid_i & ~redirect_i;
    assign imem_req_addr_o = pcf_i;
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) req_pc <= '0;
        else if (hs) req_pc <= pcf_i;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = REQ;
            REQ:     state_n = hs ? WAIT : REQ;
            WAIT:    state_n = imem_rsp_valid_i ? REQ : redirect_i ? DRAIN : WAIT;
            DRAIN:   state_n = imem_rsp_valid_i ? REQ : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        imem_req_valid_o = (state == REQ) & free & ~redirect_i;
        pc_en_o          = redirect_i | accept;
    end
    fetch_buf #(.WIDTH(WIDTH)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .flush      (redirect_i),
        .cons       (cons),
        .load_instr (imem_rsp_data_i),
        .load_pc    (req_pc),
        .valid      (instr_valid_o),
        .instr      (instr_o),
        .pc         (instr_pc_o)
    );
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table plus randomized run against a transaction-level model
module tb_fetch_ctrl;
    import fetch_pkg::*;
    localparam logic Y = 1'b1, N = 1'b0;
    localparam logic [31:0] I0 = 32'h00500093, I1 = 32'h00108113;
    logic clk = 1'b1;
    always #5 clk = ~clk;
    logic rst, redirect_i, stall_d_i, pc_en_o, imem_req_valid_o, imem_req_ready_i, imem_rsp_valid_i, instr_valid_o;
    logic [31:0] pcf_i, imem_req_addr_o, imem_rsp_data_i, instr_o, instr_pc_o, tgt;
    int checks = 0, passed = 0;
    fetch_ctrl dut (
        .clk(clk), .rst(rst), .pcf_i(pcf_i), .redirect_i(redirect_i), .stall_d_i(stall_d_i),
        .pc_en_o(pc_en_o), .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
        .imem_req_ready_i(imem_req_ready_i), .imem_rsp_valid_i(imem_rsp_valid_i),
        .imem_rsp_data_i(imem_rsp_data_i), .instr_valid_o(instr_valid_o),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o)
    );
    // Environment PC register: +4 on enable, target on redirect
    always @(posedge clk) pcf_i <= rst ? 32'h0 : pc_en_o ? (redirect_i ? tgt : pcf_i + 32'd4) : pcf_i;
    typedef struct {
        logic rst, redir;
        logic [31:0] tgt;
        logic stall, ready, rspv;
        logic [31:0] rdat;
        logic e_req;
        logic [31:0] e_addr;
        logic e_pe, e_iv;
        logic [31:0] e_instr, e_ipc;
    } vec_t;
    vec_t v[$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask
    task automatic drive(input logic r, input logic rd, input logic [31:0] t, input logic st,
                         input logic rdy, input logic rv, input logic [31:0] rdat);
        rst = r; redirect_i = rd; tgt = t; stall_d_i = st;
        imem_req_ready_i = rdy; imem_rsp_valid_i = rv; imem_rsp_data_i = rdat;
    endtask
    logic m_started, m_pend, m_disc, m_bv, cons, free, e_req, e_pe, load, hs;
    logic r, rd, st, rdy, rv;
    logic [31:0] m_req_pc, m_bi, m_bp, rdat;
    logic mem_busy;
    int mem_lat;
    initial begin
        v.push_back('{Y,N,0,N,Y,N,0, N,0,N,N,NOP_INSTR,0});
        v.push_back('{Y,N,0,N,Y,N,0, N,0,N,N,NOP_INSTR,0});
        v.push_back('{N,N,0,N,Y,N,0, N,0,N,N,NOP_INSTR,0});
        v.push_back('{N,N,0,N,Y,N,0, Y,0,N,N,NOP_INSTR,0});
        v.push_back('{N,N,0,N,Y,Y,I0, N,0,Y,N,NOP_INSTR,0});
        v.push_back('{N,N,0,N,Y,N,0, Y,4,N,Y,I0,0});
        v.push_back('{N,N,0,N,Y,Y,I1, N,0,Y,N,I0,0});
        v.push_back('{N,N,0,Y,Y,N,0, N,0,N,Y,I1,4});
        v.push_back('{N,N,0,Y,Y,N,0, N,0,N,Y,I1,4});
        v.push_back('{N,N,0,N,Y,N,0, Y,8,N,Y,I1,4});
        v.push_back('{N,Y,'h40,N,Y,N,0, N,0,Y,N,I1,4});
        v.push_back('{N,N,0,N,Y,N,0, N,0,N,N,I1,4});
        v.push_back('{N,N,0,N,Y,Y,'hDEAD, N,0,N,N,I1,4});
        v.push_back('{N,N,0,N,Y,N,0, Y,'h40,N,N,I1,4});
        v.push_back('{N,Y,'h10,N,Y,Y,'hBEEF, N,0,Y,N,I1,4});
        for (int i = 0; i < 4; i++) v.push_back('{N,N,0,N,N,N,0, Y,'h10,N,N,I1,4});
        v.push_back('{N,N,0,N,Y,N,0, Y,'h10,N,N,I1,4});
        v.push_back('{N,Y,'h20,N,Y,N,0, N,0,Y,N,I1,4});
        v.push_back('{Y,N,0,N,Y,N,0, N,0,N,N,NOP_INSTR,0});
        v.push_back('{Y,N,0,N,Y,N,0, N,0,N,N,NOP_INSTR,0});
        v.push_back('{N,N,0,N,Y,Y,'hCAFE, N,0,N,N,NOP_INSTR,0});
        v.push_back('{N,N,0,N,Y,N,0, Y,0,N,N,NOP_INSTR,0});
        foreach (v[i]) begin
            drive(v[i].rst, v[i].redir, v[i].tgt, v[i].stall, v[i].ready, v[i].rspv, v[i].rdat);
            @(negedge clk);
            if (!v[i].rst) begin
                chk($sformatf("vec%0d req_valid", i), 32'(imem_req_valid_o), 32'(v[i].e_req));
                chk($sformatf("vec%0d pc_en", i), 32'(pc_en_o), 32'(v[i].e_pe));
                chk($sformatf("vec%0d instr_valid", i), 32'(instr_valid_o), 32'(v[i].e_iv));
                chk($sformatf("vec%0d instr", i), instr_o, v[i].e_instr);
                chk($sformatf("vec%0d instr_pc", i), instr_pc_o, v[i].e_ipc);
                if (v[i].e_req) chk($sformatf("vec%0d req_addr", i), imem_req_addr_o, v[i].e_addr);
            end
            @(posedge clk); #1;
        end
        mem_busy = 0; mem_lat = 0;
        for (int c = 0; c < 3000; c++) begin
            r   = (c < 2) || ($urandom_range(0, 199) == 0);
            rd  = ($urandom_range(0, 9) == 0);
            st  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            rv  = mem_busy && (mem_lat == 0);
            rdat = $urandom;
            drive(r, rd, $urandom & ~32'h3, st, rdy, rv, rdat);
            @(negedge clk);
            cons = m_bv & ~st;
            free = ~m_bv | cons;
            e_req = m_started & ~m_pend & free & ~rd;
            e_pe = rd | (m_pend & ~m_disc & rv);
            hs = imem_req_valid_o & rdy;
            if (!r) begin
                chk("rnd req_valid", 32'(imem_req_valid_o), 32'(e_req));
                chk("rnd pc_en", 32'(pc_en_o), 32'(e_pe));
                chk("rnd instr_valid", 32'(instr_valid_o), 32'(m_bv));
                if (m_bv) chk("rnd instr", instr_o, m_bi);
                if (m_bv) chk("rnd instr_pc", instr_pc_o, m_bp);
                if (e_req) chk("rnd req_addr", imem_req_addr_o, pcf_i);
            end
            if (r) begin
                m_started = 0; m_pend = 0; m_disc = 0; m_req_pc = 0;
                m_bv = 0; m_bi = NOP_INSTR; m_bp = 0; mem_busy = 0;
            end else begin
                load = m_pend & ~m_disc & rv & ~rd;
                if (rd) m_bv = 0;
                else if (load) begin m_bv = 1; m_bi = rdat; m_bp = m_req_pc; end
                else if (cons) m_bv = 0;
                if (m_pend & rv) m_pend = 0;
                else if (m_pend & rd) m_disc = 1;
                if (e_req & rdy) begin m_pend = 1; m_disc = 0; m_req_pc = pcf_i; end
                m_started = 1;
                if (rv) mem_busy = 0;
                else if (mem_busy) mem_lat--;
                if (hs) begin mem_busy = 1; mem_lat = $urandom_range(0, 2); end
            end
            @(posedge clk); #1;
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
